// File: rtl/seq_mult_control.sv
// rtl/seq_mult_control.sv - Moore control FSM for a shift/add sequential multiplier
module seq_mult_control #(
  parameter  int Word_Length = 8,
  localparam int CNT_W       = (Word_Length > 2) ? $clog2(Word_Length) : 1
) (
  input  logic             clk,
  input  logic             reset_Input,
  input  logic             start,
  input  logic             signed_mode,
  input  logic             abort,
  output logic             Load_Enable_output,
  output logic             Enable_output,
  output logic             Correct_output,
  output logic             Ready_output,
  output logic             Done_output,
  output logic [CNT_W-1:0] Count_output,
  output logic [2:0]       State_output
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RUN     = 3'd2,
    S_CORRECT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(Word_Length - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             mode_q, mode_d;

  // Next-state rules; abort overrides the normal transition in the working states
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (start) begin
          state_d = S_LOAD;
          mode_d  = signed_mode;
        end
      end
      S_LOAD: begin
        count_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // The counter stops at the last index instead of wrapping
        if (count_q == LAST_CNT) begin
          state_d = mode_q ? S_CORRECT : S_DONE;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      S_CORRECT: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        count_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
    if (abort && (state_q == S_LOAD || state_q == S_RUN || state_q == S_CORRECT)) begin
      state_d = S_IDLE;
      count_d = '0;
    end
  end

  // State, counter, mode latch and strobes registered together so every strobe
  // always matches the registered state it belongs to
  always_ff @(posedge clk) begin
    if (reset_Input) begin
      state_q            <= S_IDLE;
      count_q            <= '0;
      mode_q             <= 1'b0;
      Ready_output       <= 1'b1;
      Load_Enable_output <= 1'b0;
      Enable_output      <= 1'b0;
      Correct_output     <= 1'b0;
      Done_output        <= 1'b0;
    end else begin
      state_q            <= state_d;
      count_q            <= count_d;
      mode_q             <= mode_d;
      Ready_output       <= (state_d == S_IDLE);
      Load_Enable_output <= (state_d == S_LOAD);
      Enable_output      <= (state_d == S_RUN);
      Correct_output     <= (state_d == S_CORRECT);
      Done_output        <= (state_d == S_DONE);
    end
  end

  assign Count_output = count_q;
  assign State_output = state_q;

endmodule

// File: tb/tb_seq_mult_control.sv
// tb/tb_seq_mult_control.sv - self-checking bench for seq_mult_control
module tb_seq_mult_control;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_Input = 1'b1;
  logic start = 1'b0;
  logic signed_mode = 1'b0;
  logic abort = 1'b0;
  logic start2 = 1'b0;
  logic start16 = 1'b0;

  logic       load_en, en, corr, ready, done;
  logic [2:0] cnt;
  logic [2:0] st;

  logic       load_en2, en2, corr2, ready2, done2;
  logic [0:0] cnt2;
  logic [2:0] st2;

  logic       load_en16, en16, corr16, ready16, done16;
  logic [3:0] cnt16;
  logic [2:0] st16;

  int checks = 0;
  int fails  = 0;

  seq_mult_control #(.Word_Length(W)) dut (
    .clk(clk), .reset_Input(reset_Input), .start(start), .signed_mode(signed_mode), .abort(abort),
    .Load_Enable_output(load_en), .Enable_output(en), .Correct_output(corr),
    .Ready_output(ready), .Done_output(done), .Count_output(cnt), .State_output(st)
  );

  seq_mult_control #(.Word_Length(2)) dut2 (
    .clk(clk), .reset_Input(reset_Input), .start(start2), .signed_mode(signed_mode), .abort(abort),
    .Load_Enable_output(load_en2), .Enable_output(en2), .Correct_output(corr2),
    .Ready_output(ready2), .Done_output(done2), .Count_output(cnt2), .State_output(st2)
  );

  seq_mult_control #(.Word_Length(16)) dut16 (
    .clk(clk), .reset_Input(reset_Input), .start(start16), .signed_mode(signed_mode), .abort(abort),
    .Load_Enable_output(load_en16), .Enable_output(en16), .Correct_output(corr16),
    .Ready_output(ready16), .Done_output(done16), .Count_output(cnt16), .State_output(st16)
  );

  // Strobes one-hot-or-none and Ready only in IDLE, for all three builds, every cycle
  always @(negedge clk) begin
    checks++;
    if ($countones({load_en, en, corr, done}) > 1 || (ready && st != 3'd0) ||
        $countones({load_en2, en2, corr2, done2}) > 1 || (ready2 && st2 != 3'd0) ||
        $countones({load_en16, en16, corr16, done16}) > 1 || (ready16 && st16 != 3'd0)) begin
      fails++;
      $display("FAIL strobe_exclusion: w8=%b w2=%b w16=%b required at most one strobe, ready only in IDLE",
               {ready, load_en, en, corr, done}, {ready2, load_en2, en2, corr2, done2},
               {ready16, load_en16, en16, corr16, done16});
    end
  end

  // Reference model: an operation is a precomputed list of (state, count) phases
  typedef struct { int s; int c; } phase_t;
  phase_t plan[$];
  int cur_st = 0;
  int cur_cnt = 0;

  task automatic tick();
    phase_t e;
    @(posedge clk);
    if (reset_Input) begin
      plan.delete(); cur_st = 0; cur_cnt = 0;
    end else if (abort && cur_st >= 1 && cur_st <= 3) begin
      plan.delete(); cur_st = 0; cur_cnt = 0;
    end else if (cur_st == 0) begin
      if (start) begin
        plan.delete();
        for (int i = 0; i < W; i++) plan.push_back('{2, i});
        if (signed_mode) plan.push_back('{3, W - 1});
        plan.push_back('{4, W - 1});
        cur_st = 1; cur_cnt = 0;
      end
    end else if (plan.size() > 0) begin
      e = plan.pop_front(); cur_st = e.s; cur_cnt = e.c;
    end else begin
      cur_st = 0; cur_cnt = 0;
    end
    @(negedge clk);
  endtask

  // Drives one operation from the start edge and measures it (k=0 is the start edge)
  task automatic run_op(input int budget, input bit toggle_mode,
                        output int n_load, output int n_en, output int n_corr, output int n_done,
                        output int done_at, output int corr_at, output int corr_cnt, output bit seq_ok);
    n_load = 0; n_en = 0; n_corr = 0; n_done = 0;
    done_at = -1; corr_at = -1; corr_cnt = -1; seq_ok = 1'b1;
    start = 1'b1;
    for (int k = 0; k < budget; k++) begin
      tick();
      start = 1'b0;
      if (toggle_mode) signed_mode = ~signed_mode;
      if (load_en) n_load++;
      if (en) begin
        n_en++;
        if (int'(cnt) != k - 1) seq_ok = 1'b0;
      end
      if (corr) begin n_corr++; corr_at = k; corr_cnt = int'(cnt); end
      if (done) begin n_done++; if (done_at < 0) done_at = k; end
    end
  endtask

  task automatic test_reset();
    reset_Input = 1'b1; start = 1'b1;
    tick(); tick();
    reset_Input = 1'b0; start = 1'b0;
    checks++;
    if ({ready, load_en, en, corr, done} !== 5'b10000) begin
      fails++; $display("FAIL reset_strobes: got %b required 10000", {ready, load_en, en, corr, done});
    end
    checks++;
    if (st !== 3'd0 || cnt !== 3'd0) begin
      fails++; $display("FAIL reset_state: got state=%0d count=%0d required 0/0", st, cnt);
    end
    tick();
    checks++;
    if (st !== 3'd0) begin
      fails++; $display("FAIL reset_start_ignored: got state=%0d required 0", st);
    end
  endtask

  task automatic test_unsigned();
    int nl, ne, nc, nd, da, ca, cc; bit ok;
    signed_mode = 1'b0;
    run_op(W + 6, 1'b0, nl, ne, nc, nd, da, ca, cc, ok);
    checks++;
    if (nl != 1 || ne != W || !ok) begin
      fails++; $display("FAIL unsigned_run: load=%0d enable=%0d seq_ok=%0b required 1/%0d/1", nl, ne, ok, W);
    end
    checks++;
    if (nd != 1 || da != W + 1 || nc != 0) begin
      fails++; $display("FAIL unsigned_done: done=%0d at edge %0d correct=%0d required 1 at %0d, 0", nd, da, nc, W + 1);
    end
    checks++;
    if (ready !== 1'b1 || st !== 3'd0 || cnt !== 3'd0) begin
      fails++; $display("FAIL unsigned_idle: ready=%b state=%0d count=%0d required 1/0/0", ready, st, cnt);
    end
  endtask

  task automatic test_signed();
    int nl, ne, nc, nd, da, ca, cc; bit ok;
    signed_mode = 1'b1;
    run_op(W + 6, 1'b1, nl, ne, nc, nd, da, ca, cc, ok);
    signed_mode = 1'b0;
    checks++;
    if (ne != W || !ok) begin
      fails++; $display("FAIL signed_run: enable=%0d seq_ok=%0b required %0d/1", ne, ok, W);
    end
    checks++;
    if (nc != 1 || ca != W + 1 || cc != W - 1) begin
      fails++; $display("FAIL signed_correct: count=%0d at edge %0d cnt=%0d required 1 at %0d cnt=%0d", nc, ca, cc, W + 1, W - 1);
    end
    checks++;
    if (nd != 1 || da != W + 2) begin
      fails++; $display("FAIL signed_done: done=%0d at edge %0d required 1 at %0d", nd, da, W + 2);
    end
  endtask

  task automatic test_abort();
    int guard; int nd;
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    checks++;
    if (st !== 3'd1) begin
      fails++; $display("FAIL abort_idle_ignored: got state=%0d required 1", st);
    end
    guard = 0;
    while (!(en && cnt == 3'd4) && guard < 20) begin tick(); guard++; end
    checks++;
    if (guard >= 20) begin
      fails++; $display("FAIL abort_reach_count4: got count=%0d required 4 within 20 cycles", cnt);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (st !== 3'd0 || cnt !== 3'd0 || ready !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL abort_to_idle: state=%0d count=%0d ready=%b done=%b required 0/0/1/0", st, cnt, ready, done);
    end
    nd = 0;
    for (int i = 0; i < W + 4; i++) begin tick(); if (done) nd++; end
    checks++;
    if (nd != 0) begin
      fails++; $display("FAIL abort_no_done: got %0d done pulses required 0", nd);
    end
  endtask

  task automatic test_reset_midrun();
    int guard;
    start = 1'b1; tick(); start = 1'b0;
    guard = 0;
    while (!(en && cnt == 3'd5) && guard < 20) begin tick(); guard++; end
    checks++;
    if (guard >= 20) begin
      fails++; $display("FAIL midrun_reach_count5: got count=%0d required 5 within 20 cycles", cnt);
    end
    reset_Input = 1'b1; start = 1'b1;
    tick();
    reset_Input = 1'b0; start = 1'b0;
    checks++;
    if ({ready, load_en, en, corr, done} !== 5'b10000 || st !== 3'd0 || cnt !== 3'd0) begin
      fails++; $display("FAIL midrun_reset: strobes=%b state=%0d count=%0d required 10000/0/0",
                        {ready, load_en, en, corr, done}, st, cnt);
    end
    tick();
    checks++;
    if (st !== 3'd0) begin
      fails++; $display("FAIL midrun_reset_start_ignored: got state=%0d required 0", st);
    end
  endtask

  task automatic test_back_to_back();
    int nd, nl; bit after_done_ok; bit prev_done;
    nd = 0; nl = 0; after_done_ok = 1'b1; prev_done = 1'b0;
    signed_mode = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3 * (W + 3); i++) begin
      tick();
      if (prev_done && st !== 3'd0) after_done_ok = 1'b0;
      prev_done = done;
      if (done) nd++;
      if (load_en) nl++;
    end
    start = 1'b0;
    tick();
    checks++;
    if (nd != 3 || nl != 3) begin
      fails++; $display("FAIL back_to_back_count: done=%0d load=%0d required 3/3", nd, nl);
    end
    checks++;
    if (!after_done_ok) begin
      fails++; $display("FAIL back_to_back_done_ignores_start: got non-IDLE after DONE required IDLE");
    end
  endtask

  task automatic test_widths();
    int ne2, ne16, nd2, nd16;
    ne2 = 0; ne16 = 0; nd2 = 0; nd16 = 0;
    start2 = 1'b1; start16 = 1'b1;
    tick();
    start2 = 1'b0; start16 = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (en2) ne2++;
      if (en16) ne16++;
      if (done2) nd2++;
      if (done16) nd16++;
    end
    checks++;
    if (ne2 != 2 || nd2 != 1) begin
      fails++; $display("FAIL width2_run: enable=%0d done=%0d required 2/1", ne2, nd2);
    end
    checks++;
    if (ne16 != 16 || nd16 != 1) begin
      fails++; $display("FAIL width16_run: enable=%0d done=%0d required 16/1", ne16, nd16);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset_Input = ($urandom_range(0, 79) == 0);
      start       = ($urandom_range(0, 2) == 0);
      signed_mode = $urandom_range(0, 1) == 1;
      abort       = ($urandom_range(0, 19) == 0);
      tick();
      checks++;
      if ({ready, load_en, en, corr, done} !== {cur_st == 0, cur_st == 1, cur_st == 2, cur_st == 3, cur_st == 4} ||
          st !== 3'(cur_st)) begin
        fails++; $display("FAIL random_state cycle %0d: state=%0d strobes=%b required state=%0d", i, st,
                          {ready, load_en, en, corr, done}, cur_st);
      end
      if (cur_st != 4) begin
        checks++;
        if (cnt !== 3'(cur_cnt)) begin
          fails++; $display("FAIL random_count cycle %0d: got %0d required %0d", i, cnt, cur_cnt);
        end
      end
    end
    reset_Input = 1'b1; start = 1'b0; abort = 1'b0;
    tick();
    reset_Input = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_unsigned();
    test_signed();
    test_abort();
    test_reset_midrun();
    test_back_to_back();
    test_widths();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
